// File: rtl/pim_sched_pkg.sv
// ---------------------------------------------------------------------------
// pim_sched_pkg
// Shared definitions for the PIM tile scheduler: geometry constants, the
// scheduler state encoding, index/counter types and the saturating
// increment used by every statistics counter.
// ---------------------------------------------------------------------------
package pim_sched_pkg;

  localparam int NUM_TILES  = 4096;
  localparam int META_WIDTH = 32;
  localparam int META_DEPTH = 128;
  localparam int CNT_WIDTH  = 32;

  localparam int TILE_W  = $clog2(NUM_TILES);   // tile index width
  localparam int LEN_W   = TILE_W + 1;          // 0..NUM_TILES inclusive
  localparam int META_AW = $clog2(META_DEPTH);  // metadata word index
  localparam int META_BW = $clog2(META_WIDTH);  // bit-within-word index

  typedef logic [TILE_W-1:0]     tile_t;
  typedef logic [LEN_W-1:0]      len_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [META_AW-1:0]    meta_addr_t;
  typedef logic [META_WIDTH-1:0] meta_word_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pim_meta_table.sv
// ---------------------------------------------------------------------------
// pim_meta_table
// Sparsity metadata store: META_DEPTH words of META_WIDTH bits, one bit per
// tile (bit b of word w covers tile w*META_WIDTH+b). A set bit marks the
// tile as active. Reset fills the table with ones so every tile is active.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (table -> all ones)
//   i_we     word write strobe (already qualified by the caller)
//   i_waddr  word index to write
//   i_wdata  word value
//   i_rtile  tile index to look up
//   o_rbit   metadata bit for i_rtile (combinational read)
// ---------------------------------------------------------------------------
module pim_meta_table
  import pim_sched_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [META_AW-1:0]    i_waddr,
  input  logic [META_WIDTH-1:0] i_wdata,
  input  logic [TILE_W-1:0]     i_rtile,
  output logic                  o_rbit
);

  meta_word_t r_mem [META_DEPTH];

  logic [META_AW-1:0] w_rword;
  logic [META_BW-1:0] w_rbit;

  assign w_rword = i_rtile[TILE_W-1:META_BW];
  assign w_rbit  = i_rtile[META_BW-1:0];
  assign o_rbit  = r_mem[w_rword][w_rbit];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < META_DEPTH; i++) begin
        r_mem[i] <= '1;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/pim_tile_scheduler.sv
// ---------------------------------------------------------------------------
// pim_tile_scheduler
// Walks a contiguous (wrapping) range of tiles, issuing each active tile to
// the PIM MAC datapath over a valid/ack handshake and skipping tiles whose
// sparsity metadata bit is 0. Keeps MAC-op, skipped-tile, active-cycle and
// idle-cycle statistics for the performance monitor.
//
// Build option: define PIM_SPARSE_SKIP_EN to instantiate the metadata table
// and enable skipping. Without it every tile is issued, metadata writes are
// ignored, meta_err never pulses and skipped_tiles stays 0.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   meta_we/addr/wdata  metadata word write (accepted only while IDLE)
//   start, abort    job start pulse / terminate current job
//   job_base/len    first tile and tile count (0..NUM_TILES)
//   busy, done      job in progress / one-cycle completion pulse
//   meta_err        one-cycle pulse: metadata write rejected while busy
//   mac_req/tile    tile issue valid and index; mac_ack accepts
//   stats_clr       clear all statistics counters
//   mac_ops_count, skipped_tiles, active_cycles, idle_cycles  statistics
// All outputs are registered.
// ---------------------------------------------------------------------------
module pim_tile_scheduler
  import pim_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  meta_we,
  input  logic [META_AW-1:0]    meta_addr,
  input  logic [META_WIDTH-1:0] meta_wdata,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TILE_W-1:0]     job_base,
  input  logic [LEN_W-1:0]      job_len,
  output logic                  busy,
  output logic                  done,
  output logic                  meta_err,
  output logic                  mac_req,
  output logic [TILE_W-1:0]     mac_tile,
  input  logic                  mac_ack,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  mac_ops_count,
  output logic [CNT_WIDTH-1:0]  skipped_tiles,
  output logic [CNT_WIDTH-1:0]  active_cycles,
  output logic [CNT_WIDTH-1:0]  idle_cycles
);

  state_t r_state;
  tile_t  r_cursor;
  len_t   r_remaining;
  logic   r_busy;
  logic   r_done;
  logic   r_meta_err;
  logic   r_mac_req;
  tile_t  r_mac_tile;
  cnt_t   r_mac_ops;
  cnt_t   r_skipped;
  cnt_t   r_active;
  cnt_t   r_idle;

  logic   w_meta_bit;
  logic   w_meta_err_evt;
  logic   w_ack_evt;
  logic   w_skip_evt;
  logic   w_last;

`ifdef PIM_SPARSE_SKIP_EN
  logic w_meta_we_ok;

  // Table may only change between jobs so a running scan sees a stable map.
  assign w_meta_we_ok   = meta_we && (r_state == S_IDLE);
  assign w_meta_err_evt = meta_we && (r_state != S_IDLE);

  pim_meta_table u_meta_table (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_meta_we_ok),
    .i_waddr (meta_addr),
    .i_wdata (meta_wdata),
    .i_rtile (r_cursor),
    .o_rbit  (w_meta_bit)
  );
`else
  logic w_unused_meta;

  assign w_meta_bit     = 1'b1;
  assign w_meta_err_evt = 1'b0;
  assign w_unused_meta  = ^{meta_we, meta_addr, meta_wdata};
`endif

  assign w_ack_evt  = (r_state == S_ISSUE) && mac_ack;
  assign w_skip_evt = (r_state == S_SCAN) && !w_meta_bit;
  assign w_last     = (r_remaining == len_t'(1));

  // Scheduler FSM. Outputs are written alongside the state they belong to,
  // so busy/done/mac_req line up with the state that is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_meta_err <= 1'b0;
      r_mac_req  <= 1'b0;
      r_mac_tile <= '0;
    end else begin
      r_done     <= 1'b0;
      r_meta_err <= w_meta_err_evt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cursor    <= job_base;
            r_remaining <= job_len;
            if (job_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_meta_bit) begin
            r_state    <= S_ISSUE;
            r_mac_req  <= 1'b1;
            r_mac_tile <= r_cursor;
          end else begin
            // Cursor is TILE_W wide, so +1 wraps the last tile back to 0.
            r_cursor    <= r_cursor + tile_t'(1);
            r_remaining <= r_remaining - len_t'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (mac_ack) begin
            r_mac_req   <= 1'b0;
            r_cursor    <= r_cursor + tile_t'(1);
            r_remaining <= r_remaining - len_t'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Abort overrides whatever the state logic chose; counters still see
      // any same-cycle ack because they are driven separately below.
      if (abort && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_mac_req <= 1'b0;
      end
    end
  end

  // Statistics; a clear beats any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_mac_ops <= '0;
      r_skipped <= '0;
      r_active  <= '0;
      r_idle    <= '0;
    end else begin
      if (w_ack_evt) begin
        r_mac_ops <= sat_inc(r_mac_ops);
      end
      if (w_skip_evt) begin
        r_skipped <= sat_inc(r_skipped);
      end
      if (r_state == S_IDLE) begin
        r_idle <= sat_inc(r_idle);
      end else begin
        r_active <= sat_inc(r_active);
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign meta_err      = r_meta_err;
  assign mac_req       = r_mac_req;
  assign mac_tile      = r_mac_tile;
  assign mac_ops_count = r_mac_ops;
  assign skipped_tiles = r_skipped;
  assign active_cycles = r_active;
  assign idle_cycles   = r_idle;

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pim_tile_scheduler
// Scoreboard bench: job stimulus pushes the expected tile sequence (derived
// from a plain bit-array model of the metadata) and one done token per job;
// a monitor on the falling edge drives mac_ack and pops/compares each
// accepted tile and each done pulse. Honours PIM_SPARSE_SKIP_EN.
// ---------------------------------------------------------------------------
module tb_pim_tile_scheduler;

`ifdef PIM_SPARSE_SKIP_EN
  localparam bit SPARSE = 1'b1;
`else
  localparam bit SPARSE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        meta_we;
  logic [6:0]  meta_addr;
  logic [31:0] meta_wdata;
  logic        start;
  logic        abort;
  logic [11:0] job_base;
  logic [12:0] job_len;
  logic        busy;
  logic        done;
  logic        meta_err;
  logic        mac_req;
  logic [11:0] mac_tile;
  logic        mac_ack;
  logic        stats_clr;
  logic [31:0] mac_ops_count;
  logic [31:0] skipped_tiles;
  logic [31:0] active_cycles;
  logic [31:0] idle_cycles;

  pim_tile_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .meta_we       (meta_we),
    .meta_addr     (meta_addr),
    .meta_wdata    (meta_wdata),
    .start         (start),
    .abort         (abort),
    .job_base      (job_base),
    .job_len       (job_len),
    .busy          (busy),
    .done          (done),
    .meta_err      (meta_err),
    .mac_req       (mac_req),
    .mac_tile      (mac_tile),
    .mac_ack       (mac_ack),
    .stats_clr     (stats_clr),
    .mac_ops_count (mac_ops_count),
    .skipped_tiles (skipped_tiles),
    .active_cycles (active_cycles),
    .idle_cycles   (idle_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] mdl_meta [128];
  int          mdl_ops;
  int          mdl_skip;
  int          exp_tiles [$];
  int          exp_done  [$];

  // Monitor bookkeeping
  int   ack_mode = 0;  // 0: ack at once, 1: random ack, 2: never ack
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_ack_cyc = 0;
  bit   prev_req = 1'b0;
  bit   prev_ack = 1'b0;
  bit   prev_abort = 1'b0;
  logic [11:0] prev_tile = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at t=%0t",
                  nm, act, act, exp, exp, $time);
  endtask

  function automatic bit mdl_bit(input int t);
    logic [31:0] w;
    w = mdl_meta[t / 32];
    return SPARSE ? w[t % 32] : 1'b1;
  endfunction

  task automatic model_write(input int wa, input logic [31:0] wd);
    if (SPARSE) mdl_meta[wa] = wd;
  endtask

  // Expected issue order: walk the range with wrap, keep active tiles.
  task automatic start_job(input int base, input int len, input bit wr,
                           input int wa, input logic [31:0] wd);
    if (wr) model_write(wa, wd);
    for (int i = 0; i < len; i++) begin
      int t;
      t = (base + i) % 4096;
      if (mdl_bit(t)) begin
        exp_tiles.push_back(t);
        mdl_ops++;
      end else begin
        mdl_skip++;
      end
    end
    exp_done.push_back(1);
    @(posedge clk); #1;
    start = 1'b1; job_base = 12'(base); job_len = 13'(len);
    meta_we = wr; meta_addr = 7'(wa); meta_wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; meta_we = 1'b0;
  endtask

  task automatic meta_write_idle(input int wa, input logic [31:0] wd);
    model_write(wa, wd);
    @(posedge clk); #1;
    meta_we = 1'b1; meta_addr = 7'(wa); meta_wdata = wd;
    @(posedge clk); #1;
    meta_we = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int n);
    n = 0;
    while (done_cnt <= d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_mac_ops"}, mac_ops_count, 32'(mdl_ops));
    chk({tag, "_skipped"}, skipped_tiles, 32'(mdl_skip));
    chk({tag, "_tiles_drained"}, 32'(exp_tiles.size()), 32'd0);
  endtask

  // Monitor / ack responder
  always @(negedge clk) begin
    bit a;
    cyc++;
    if (rst) begin
      mac_ack  = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (prev_req && !prev_ack && !prev_abort) begin
        chk("req_hold", 32'(mac_req), 32'd1);
        chk("tile_hold", 32'(mac_tile), 32'(prev_tile));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          void'(exp_done.pop_front());
          chk("done_busy_low", 32'(busy), 32'd0);
        end
      end
      a = 1'b0;
      if (mac_req) begin
        case (ack_mode)
          0:       a = 1'b1;
          1:       a = ($urandom_range(0, 2) == 0);
          default: a = 1'b0;
        endcase
      end
      if (a) begin
        chk("tile_expected", 32'(exp_tiles.size() != 0), 32'd1);
        if (exp_tiles.size() != 0) chk("mac_tile", 32'(mac_tile), 32'(exp_tiles.pop_front()));
        last_ack_cyc = cyc;
      end
      mac_ack    = a;
      prev_req   = mac_req;
      prev_ack   = a;
      prev_abort = abort;
      prev_tile  = mac_tile;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int el;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; meta_we = 1'b0; meta_addr = '0;
    meta_wdata = '0; job_base = '0; job_len = '0; stats_clr = 1'b0; mac_ack = 1'b0;
    for (int w = 0; w < 128; w++) mdl_meta[w] = '1;
    mdl_ops = 0; mdl_skip = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_meta_err", 32'(meta_err), 32'd0);
    chk("rst_mac_req", 32'(mac_req), 32'd0);
    chk("rst_mac_tile", 32'(mac_tile), 32'd0);
    chk("rst_mac_ops", mac_ops_count, 32'd0);
    chk("rst_skipped", skipped_tiles, 32'd0);
    chk("rst_active", active_cycles, 32'd0);
    chk("rst_idle", idle_cycles, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Dense job with immediate acks, latency checks
    ack_mode = 0;
    d0 = done_cnt;
    start_job(0, 4, 1'b0, 0, 32'h0);
    @(negedge clk);
    chk("start_busy_n1", 32'(busy), 32'd1);
    chk("start_req_n1", 32'(mac_req), 32'd0);
    @(negedge clk);
    chk("start_req_n2", 32'(mac_req), 32'd1);
    chk("start_tile_n2", 32'(mac_tile), 32'd0);
    wait_done(d0, n);
    chk("done_after_last_ack", 32'(done_cyc), 32'(last_ack_cyc + 1));
    check_stats("dense");

    // Sparse word 0 = 0x5: tiles 0 and 2 only
    meta_write_idle(0, 32'h0000_0005);
    @(negedge clk);
    chk("meta_err_idle_write", 32'(meta_err), 32'd0);
    d0 = done_cnt;
    start_job(0, 4, 1'b0, 0, 32'h0);
    wait_done(d0, n);
    check_stats("sparse");

    // Wrap 4095 -> 0
    d0 = done_cnt;
    start_job(4094, 4, 1'b0, 0, 32'h0);
    wait_done(d0, n);
    check_stats("wrap");

    // Held request, rejected write, ignored start, abort
    ack_mode = 2;
    @(posedge clk); #1;
    start = 1'b1; job_base = 12'd2; job_len = 13'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !mac_req; k++) @(negedge clk);
    chk("hold_req_seen", 32'(mac_req), 32'd1);
    repeat (10) @(negedge clk);
    chk("hold_req_10", 32'(mac_req), 32'd1);
    chk("hold_tile_10", 32'(mac_tile), 32'd2);
    @(posedge clk); #1;
    meta_we = 1'b1; meta_addr = 7'd0; meta_wdata = 32'h0;
    @(posedge clk); #1;
    meta_we = 1'b0;
    @(negedge clk);
    chk("meta_err_busy", 32'(meta_err), 32'(SPARSE));
    @(negedge clk);
    chk("meta_err_pulse_1cyc", 32'(meta_err), 32'd0);
    @(posedge clk); #1;
    start = 1'b1; job_base = 12'd100; job_len = 13'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy_ignored", 32'(mac_tile), 32'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(mac_req), 32'd0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_mac_ops", mac_ops_count, 32'(mdl_ops));
    ack_mode = 0;

    // Table unaffected by the rejected write
    d0 = done_cnt;
    start_job(0, 4, 1'b0, 0, 32'h0);
    wait_done(d0, n);
    check_stats("after_reject");

    // Zero-length job
    start_job(5, 0, 1'b0, 0, 32'h0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_req", 32'(mac_req), 32'd0);

    // Clear, then 20 idle cycles
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    mdl_ops = 0; mdl_skip = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle20_idle", idle_cycles, 32'd20);
    chk("idle20_active", active_cycles, 32'd0);
    chk("idle20_ops", mac_ops_count, 32'd0);

    // Clear coinciding with the first ack of a 4-tile dense job
    d0 = done_cnt;
    start_job(64, 4, 1'b0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("clr_req_seen", 32'(mac_req), 32'd1);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    el = 0;
    @(negedge clk);
    chk("clr_ops", mac_ops_count, 32'd0);
    chk("clr_skipped", skipped_tiles, 32'd0);
    chk("clr_active", active_cycles, 32'd0);
    chk("clr_idle", idle_cycles, 32'd0);
    mdl_ops = 3;  // tiles 65..67 remain to be accepted
    mdl_skip = 0;
    wait_done(d0, n);
    el += n;
    repeat (3) @(posedge clk);
    el += 3;
    @(negedge clk);
    // 3 tiles x (SCAN + ISSUE) + DONE
    chk("clr_job_active", active_cycles, 32'd7);
    chk("cycle_sum", active_cycles + idle_cycles, 32'(el));
    check_stats("clr_job");

    // Randomised jobs with random acks and metadata
    ack_mode = 1;
    for (int r = 0; r < 12; r++) begin
      int base;
      int len;
      int sel;
      logic [31:0] wd;
      base = int'($urandom_range(0, 4095));
      len  = int'($urandom_range(1, 48));
      wd   = $urandom;
      sel  = int'($urandom_range(0, 2));
      d0 = done_cnt;
      if (sel == 1) meta_write_idle(base / 32, wd);
      start_job(base, len, sel == 2, base / 32, wd);
      wait_done(d0, n);
      check_stats("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
